// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with grant lock and hold watchdog
//
// Purpose: grants one of four requesters at a time, keeps the grant locked
// until the owner pulses done, and forcibly releases it after HOLD_LIMIT
// cycles without done. All outputs are registered.
//
// Ports:
//   clk          clock, rising-edge
//   rst          asynchronous active-high reset
//   req[3:0]     request vector, bit i = requester i
//   done         owner releases the grant (only looked at while granted)
//   grant_valid  a grant is active
//   grant_idx    index of the granted requester
//   timeout      one-cycle pulse after a watchdog release
module rr_arbiter_4 #(
  parameter int HOLD_LIMIT = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [1:0] grant_idx,
  output logic       timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam bit             WD_EN    = (HOLD_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_M1 = WD_EN ? CNT_W'(HOLD_LIMIT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Returns {found, index}. Scans from last+1 upward with wrap; iterating
  // from the farthest candidate down lets the nearest one overwrite.
  function automatic logic [2:0] pick(input logic [1:0] last, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [2:0] pick_last;
  logic [2:0] pick_owner;

  assign pick_last  = pick(last_q, req);
  // On release the search must start after the current owner, since last
  // is updated at the same edge the next winner is chosen.
  assign pick_owner = pick(idx_q, req);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_last[2]) begin
          idx_d   = pick_last[1:0];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (done) begin
          // done takes precedence over a simultaneous watchdog expiry
          last_d = idx_q;
          if (pick_owner[2]) begin
            idx_d   = pick_owner[1:0];
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (WD_EN && (cnt_q == LIMIT_M1)) begin
          last_d    = idx_q;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 2'b11;
      idx_q     <= 2'b00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed self-checking bench for rr_arbiter_4
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  logic       gv16, to16;
  logic [1:0] gi16;
  logic       gv4, to4;
  logic [1:0] gi4;
  logic       gv0, to0;
  logic [1:0] gi0;

  int tests;
  int fails;

  rr_arbiter_4 #(.HOLD_LIMIT(16), .CNT_W(8)) u16 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_valid(gv16), .grant_idx(gi16), .timeout(to16)
  );

  rr_arbiter_4 #(.HOLD_LIMIT(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_valid(gv4), .grant_idx(gi4), .timeout(to4)
  );

  rr_arbiter_4 #(.HOLD_LIMIT(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_valid(gv0), .grant_idx(gi0), .timeout(to0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic v, input logic [1:0] i, input logic t);
    check({tag, ".valid"}, gv16, v);
    if (v) check({tag, ".idx"}, gi16, i);
    check({tag, ".timeout"}, to16, t);
  endtask

  task automatic chk4(input string tag, input logic v, input logic [1:0] i, input logic t);
    check({tag, ".valid"}, gv4, v);
    if (v) check({tag, ".idx"}, gi4, i);
    check({tag, ".timeout"}, to4, t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] seq [5];
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    do_reset();
    chk16("reset", 1'b0, 2'd0, 1'b0);
    check("reset.idx", gi16, 0);

    // full request vector, done every cycle: 0,1,2,3,0 back-to-back
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
    req  = 4'b1111;
    done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk16($sformatf("rr%0d", k), 1'b1, seq[k], 1'b0);
    end
    req = 4'b0000;
    tick();
    chk16("rr_drop", 1'b0, 2'd0, 1'b0);

    // sole requester 2 wins again with no gap
    done = 1'b0;
    req  = 4'b0100;
    tick();
    chk16("sole_first", 1'b1, 2'd2, 1'b0);
    done = 1'b1;
    tick();
    chk16("sole_again", 1'b1, 2'd2, 1'b0);
    req = 4'b0000;
    tick();
    chk16("sole_release", 1'b0, 2'd0, 1'b0);

    // lock: owner 1 keeps grant while req changes; next is 3 not 0
    done = 1'b0;
    req  = 4'b0010;
    tick();
    chk16("lock_grant", 1'b1, 2'd1, 1'b0);
    req = 4'b1001;
    tick();
    chk16("lock_hold", 1'b1, 2'd1, 1'b0);
    done = 1'b1;
    tick();
    chk16("lock_next", 1'b1, 2'd3, 1'b0);
    req = 4'b0000;
    tick();
    chk16("lock_release", 1'b0, 2'd0, 1'b0);

    // asynchronous reset mid-grant (last=3, requester 2 granted)
    done = 1'b0;
    req  = 4'b0100;
    tick();
    chk16("pre_rst", 1'b1, 2'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk16("async_rst", 1'b0, 2'd0, 1'b0);
    check("async_rst.idx", gi16, 0);
    rst = 1'b0;
    req = 4'b1110;
    tick();
    chk16("post_rst", 1'b1, 2'd1, 1'b0);

    // watchdog, HOLD_LIMIT=4
    req  = 4'b0000;
    done = 1'b0;
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk4($sformatf("wd_hold%0d", k), 1'b1, 2'd0, 1'b0);
    end
    tick();
    chk4("wd_fire", 1'b0, 2'd0, 1'b1);
    tick();
    chk4("wd_regrant", 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk4($sformatf("wd2_hold%0d", k), 1'b1, 2'd0, 1'b0);
    end
    done = 1'b1;
    tick();
    chk4("done_wins", 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick();
    chk4("done_release", 1'b0, 2'd0, 1'b0);

    // watchdog disabled: grant held for 100 cycles
    done = 1'b0;
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("nowd.valid", gv0, 1);
      check("nowd.timeout", to0, 0);
    end
    check("nowd.idx", gi0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
